mem_master: RTL and testbench

Initiator for the memory valid/ready port. It accepts write/read commands from a local command port into a small FIFO and drives `valid`/`wr_rd`/`addr`/`wdata` toward the `memory` responder. It captures `rdata` on read completion and returns it on a response port. A per-transfer timeout aborts any request the responder never acknowledges. It sits between the test/env-side traffic generator and the `memory` block.

---
 rtl/mem_master.sv | 155 +++++++++++++++
 tb/tb_mem_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Valid/ready memory initiator. Commands are queued in a small FIFO and issued one per
// cycle. Read results come back through a single-entry response slot, and requests that
// the responder never acknowledges are aborted after a timeout.
module mem_master #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int            PW    = $clog2(FIFO_DEPTH);
  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } cmd_t;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state_q;
  cmd_t                  fifo_q [FIFO_DEPTH];
  cmd_t                  req_q;
  logic [PW:0]           wr_ptr_q, rd_ptr_q;
  logic [TW-1:0]         tcnt_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0]      rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [7:0]            err_cnt_q;

  logic [PW:0]           count;
  logic [PW-1:0]         nxt_idx;
  cmd_t                  head, nxt, cmd_in;
  logic                  empty, full, push, rsp_free, head_ok, nxt_ok;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign cmd_ready = res && !full;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{wr_rd: cmd_wr_rd, addr: cmd_addr, wdata: cmd_wdata};

  assign nxt_idx   = rd_ptr_q[PW-1:0] + PW'(1);
  assign head      = fifo_q[rd_ptr_q[PW-1:0]];
  assign nxt       = fifo_q[nxt_idx];

  // A read may only issue if the response slot is guaranteed free by the next cycle.
  assign rsp_free  = !rsp_valid_q || rsp_ready;
  assign head_ok   = head.wr_rd || rsp_free;
  assign nxt_ok    = (count > (PW+1)'(1)) && (nxt.wr_rd || (rsp_free && req_q.wr_rd));

  assign valid     = (state_q == REQ);
  assign wr_rd     = req_q.wr_rd;
  assign addr      = req_q.addr;
  assign wdata     = req_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = !empty || (state_q != IDLE);

  // NOTE: FIFO storage has no reset; flushing the pointers is enough to make it empty,
  // and leaving the array out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= cmd_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read below sees
  // the pre-edge value; later assignments in the block intentionally override earlier ones.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q     <= IDLE;
      req_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!empty && head_ok) begin
            state_q <= REQ;
            req_q   <= head;
            tcnt_q  <= '0;
          end
        end
        REQ: begin
          if (ready) begin
            rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            tcnt_q   <= '0;
            if (!req_q.wr_rd) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= rdata;
              rsp_addr_q  <= req_q.addr;
            end
            if (nxt_ok) begin
              req_q <= nxt;
            end else begin
              state_q <= IDLE;
              req_q   <= '0;
            end
          end else if (tcnt_q == TLAST) begin
            rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            state_q  <= IDLE;
            req_q    <= '0;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (!req_q.wr_rd) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_addr_q  <= req_q.addr;
            end
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a small responder memory model plus hand-computed
// expectations for reset, issue latency, FIFO full, response backpressure and timeout.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        res;
  logic        cmd_valid, cmd_ready, cmd_wr_rd;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [3:0]  rsp_addr;
  logic        valid, wr_rd, ready, busy;
  logic [3:0]  addr;
  logic [15:0] wdata, rdata;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [16];

  always #5 clk = ~clk;

  mem_master #(.WIDTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err_cnt(err_cnt)
  );

  // Responder memory: writes land on the acknowledging edge, reads are combinational.
  always @(posedge clk) begin
    if (valid && ready && wr_rd) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [3:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_wr_rd = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic        addr_ok;
    res       = 1'b0;
    ready     = 1'b1;
    rsp_ready = 1'b1;
    idle_cmd();

    // Reset values
    step();
    step();
    check("rst_valid",     valid,     0);
    check("rst_wr_rd",     wr_rd,     0);
    check("rst_addr",      addr,      0);
    check("rst_wdata",     wdata,     0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_addr",  rsp_addr,  0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_busy",      busy,      0);
    check("rst_err_cnt",   err_cnt,   0);
    check("rst_cmd_ready", cmd_ready, 0);
    res = 1'b1;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy",      busy,      0);

    // Write then read, responder always ready
    drive_cmd(1'b1, 4'd3, 16'hA5A5);
    step();
    drive_cmd(1'b0, 4'd3, 16'h0000);
    step();
    idle_cmd();
    check("wr_valid", valid, 1);
    check("wr_wr_rd", wr_rd, 1);
    check("wr_addr",  addr,  3);
    check("wr_wdata", wdata, 16'hA5A5);
    step();
    check("rd_valid", valid, 1);
    check("rd_wr_rd", wr_rd, 0);
    check("rd_addr",  addr,  3);
    step();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 16'hA5A5);
    check("rd_rsp_addr",  rsp_addr,  3);
    check("rd_rsp_err",   rsp_err,   0);
    check("rd_done_valid", valid, 0);
    step();
    check("rd_rsp_cleared", rsp_valid, 0);
    check("rd_idle_busy",   busy,      0);

    // FIFO full, then back-to-back drain
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 4'(i), 16'h1000 + 16'(i));
      step();
      if (i == 2) check("full_stall_addr", addr, 0);
    end
    idle_cmd();
    check("full_cmd_ready", cmd_ready, 0);
    check("full_valid",     valid,     1);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", valid, 1);
      check("b2b_addr",  addr,  32'(i));
      check("b2b_wdata", wdata, 32'h1000 + 32'(i));
      if (i == 1) check("b2b_cmd_ready", cmd_ready, 1);
      step();
    end
    check("b2b_end_valid", valid, 0);

    // Response backpressure with two reads
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 4'd1, 16'h0000);
    step();
    drive_cmd(1'b0, 4'd2, 16'h0000);
    step();
    idle_cmd();
    check("bp_rd1_valid", valid, 1);
    check("bp_rd1_addr",  addr,  1);
    step();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_rdata", rsp_rdata, 16'h1001);
    check("bp_rsp_addr",  rsp_addr,  1);
    check("bp_hold_valid0", valid, 0);
    step();
    check("bp_hold_rsp", rsp_valid, 1);
    check("bp_hold_valid1", valid, 0);
    step();
    check("bp_hold_valid2", valid, 0);
    rsp_ready = 1'b1;
    step();
    check("bp_rd2_valid", valid, 1);
    check("bp_rd2_addr",  addr,  2);
    check("bp_rsp_taken", rsp_valid, 0);
    step();
    check("bp_rsp2_valid", rsp_valid, 1);
    check("bp_rsp2_rdata", rsp_rdata, 16'h1002);
    check("bp_rsp2_addr",  rsp_addr,  2);
    step();
    check("bp_end_rsp", rsp_valid, 0);
    check("bp_end_busy", busy, 0);

    // Timeout on a read the responder never acknowledges
    ready = 1'b0;
    drive_cmd(1'b0, 4'd7, 16'h0000);
    step();
    idle_cmd();
    step();
    n       = 0;
    addr_ok = 1'b1;
    while (valid === 1'b1 && n < 40) begin
      if (addr !== 4'd7 || wr_rd !== 1'b0) addr_ok = 1'b0;
      n++;
      step();
    end
    check("to_valid_cycles", n, 15);
    check("to_addr_stable",  addr_ok, 1);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err",   rsp_err,   1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_rsp_addr",  rsp_addr,  7);
    check("to_err_cnt",   err_cnt,   1);
    ready = 1'b1;
    drive_cmd(1'b1, 4'd5, 16'hBEEF);
    step();
    idle_cmd();
    step();
    check("to_wr_valid", valid, 1);
    check("to_wr_wr_rd", wr_rd, 1);
    check("to_wr_addr",  addr,  5);
    check("to_wr_wdata", wdata, 16'hBEEF);
    step();
    check("to_wr_done",  valid,   0);
    check("to_err_keep", err_cnt, 1);
    check("to_rsp_err_cleared", rsp_valid, 0);

    // Reset in the middle of a stalled transfer with a response pending
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 4'd5, 16'h0000);
    step();
    drive_cmd(1'b1, 4'd8, 16'h0808);
    step();
    check("mr_rd_valid", valid, 1);
    check("mr_rd_addr",  addr,  5);
    drive_cmd(1'b1, 4'd9, 16'h0909);
    step();
    check("mr_rsp_valid", rsp_valid, 1);
    check("mr_rsp_rdata", rsp_rdata, 16'hBEEF);
    check("mr_wr_valid",  valid, 1);
    check("mr_wr_addr",   addr,  8);
    ready = 1'b0;
    drive_cmd(1'b1, 4'd10, 16'h0A0A);
    step();
    idle_cmd();
    check("mr_stall_valid", valid, 1);
    check("mr_stall_addr",  addr,  8);
    check("mr_stall_busy",  busy,  1);
    res = 1'b0;
    step();
    check("mr_valid",     valid,     0);
    check("mr_busy",      busy,      0);
    check("mr_rsp_valid_clr", rsp_valid, 0);
    check("mr_err_cnt",   err_cnt,   0);
    check("mr_cmd_ready", cmd_ready, 0);
    res       = 1'b1;
    ready     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mr_post_valid", valid, 0);
    end
    check("mr_post_busy", busy, 0);
    check("mr_post_rsp",  rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
